// File: rtl/mem_wr_sched_pkg.sv
// Shared types and byte-lane helpers for the data-memory write scheduler.
package mem_wr_pkg;

  localparam int unsigned ENT_AW = 64;
  localparam int unsigned ENT_DW = 64;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic {
    RR_S0 = 1'b0,
    RR_S1 = 1'b1
  } rr_e;

  typedef struct packed {
    logic [ENT_AW-1:0] addr;
    logic [7:0]        wmask;
    logic [ENT_DW-1:0] wdata;
  } wr_entry_t;

  function automatic logic [7:0] size_mask(input logic [1:0] size, input logic [2:0] off);
    logic [7:0]  base;
    logic [15:0] sh;
    case (size)
      SZ_B:    base = 8'h01;
      SZ_H:    base = 8'h03;
      SZ_W:    base = 8'h0f;
      default: base = 8'hff;
    endcase
    sh = {8'h00, base} << off;
    return sh[7:0];
  endfunction

  function automatic logic [63:0] lane_data(input logic [63:0] data, input logic [1:0] size,
                                            input logic [2:0] off);
    logic [63:0] keep;
    case (size)
      SZ_B:    keep = 64'h0000_0000_0000_00ff;
      SZ_H:    keep = 64'h0000_0000_0000_ffff;
      SZ_W:    keep = 64'h0000_0000_ffff_ffff;
      default: keep = 64'hffff_ffff_ffff_ffff;
    endcase
    return (data & keep) << {off, 3'b000};
  endfunction

  function automatic logic misaligned(input logic [2:0] off, input logic [1:0] size);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return off[0];
      SZ_W:    return |off[1:0];
      default: return |off;
    endcase
  endfunction

endpackage

// File: rtl/mem_wr_sched_wr_queue.sv
// In-order store queue of wr_entry_t; full/empty resolved by an explicit count.
module wr_queue
  import mem_wr_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enq,
  input  wr_entry_t                    enq_data,
  input  logic                         deq,
  output wr_entry_t                    head_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  wr_entry_t       mem [DEPTH];
  logic [IW-1:0]   head;
  logic [IW-1:0]   tail;
  logic [CW-1:0]   cnt;
  logic            do_enq;
  logic            do_deq;

  always_comb begin
    full      = (cnt == CW'(DEPTH));
    empty     = (cnt == '0);
    do_enq    = enq & ~full;
    do_deq    = deq & ~empty;
    head_data = mem[head];
    count     = cnt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (do_enq) tail <= tail + IW'(1);
      if (do_deq) head <= head + IW'(1);
      case ({do_enq, do_deq})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst && do_enq) mem[tail] <= enq_data;
  end

endmodule

// File: rtl/mem_wr_sched.sv
// Two-requester store arbiter: alignment check, byte-lane transform, in-order drain to memory.
module mem_wr_sched
  import mem_wr_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 64,
  parameter int unsigned DW    = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s0_valid,
  output logic          s0_ready,
  input  logic [AW-1:0] s0_addr,
  input  logic [1:0]    s0_size,
  input  logic [DW-1:0] s0_data,
  input  logic          s1_valid,
  output logic          s1_ready,
  input  logic [AW-1:0] s1_addr,
  input  logic [1:0]    s1_size,
  input  logic [DW-1:0] s1_data,
  output logic          mem_wen,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wmask,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  output logic          q_empty,
  output logic          misalign,
  output logic [AW-1:0] misalign_addr
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  rr_e             rr, rr_nxt;
  logic            grant0, grant1;
  logic            accept, mis, enq, deq;
  logic [AW-1:0]   sel_addr;
  logic [1:0]      sel_size;
  logic [DW-1:0]   sel_data;
  wr_entry_t       ent;
  wr_entry_t       head;
  logic [CW-1:0]   q_count;
  logic            q_full, q_none;

  always_comb begin
    grant0   = s0_valid & (~s1_valid | (rr == RR_S0));
    grant1   = s1_valid & (~s0_valid | (rr == RR_S1));
    s0_ready = grant0 & ~q_full;
    s1_ready = grant1 & ~q_full;
    accept   = s0_ready | s1_ready;
    sel_addr = s1_ready ? s1_addr : s0_addr;
    sel_size = s1_ready ? s1_size : s0_size;
    sel_data = s1_ready ? s1_data : s0_data;
    mis      = misaligned(sel_addr[2:0], sel_size);
    enq      = accept & ~mis;
    ent.addr  = ENT_AW'(sel_addr);
    ent.wmask = size_mask(sel_size, sel_addr[2:0]);
    ent.wdata = lane_data(sel_data, sel_size, sel_addr[2:0]);
  end

  always_comb begin
    rr_nxt = rr;
    if (s0_ready)      rr_nxt = RR_S1;
    else if (s1_ready) rr_nxt = RR_S0;
  end

  // Misaligned requests complete the handshake but only leave a trace in misalign/misalign_addr.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rr            <= RR_S0;
      misalign      <= 1'b0;
      misalign_addr <= '0;
    end else begin
      rr       <= rr_nxt;
      misalign <= accept & mis;
      if (accept && mis) misalign_addr <= sel_addr;
    end
  end

  wr_queue #(.DEPTH(DEPTH)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .enq       (enq),
    .enq_data  (ent),
    .deq       (deq),
    .head_data (head),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_none)
  );

  always_comb begin
    mem_wen   = ~q_none;
    deq       = mem_wen & mem_ready;
    q_empty   = (q_count == '0);
    mem_addr  = q_none ? '0 : AW'(head.addr);
    mem_wmask = q_none ? '0 : head.wmask;
    mem_wdata = q_none ? '0 : DW'(head.wdata);
  end

endmodule

// File: tb/tb_mem_wr_sched.sv
// Bench for mem_wr_sched: vector table plus hand sequences, drain order checked by a scoreboard.
module tb_mem_wr_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        s0_valid, s1_valid, mem_ready;
  logic        s0_ready, s1_ready;
  logic [63:0] s0_addr, s1_addr, s0_data, s1_data;
  logic [1:0]  s0_size, s1_size;
  logic        mem_wen, q_empty, misalign;
  logic [63:0] mem_addr, mem_wdata, misalign_addr;
  logic [7:0]  mem_wmask;

  int unsigned compared = 0;
  int unsigned mismatched = 0;

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  m;
    logic [63:0] d;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic v0; logic [63:0] a0; logic [1:0] z0; logic [63:0] d0;
    logic v1; logic [63:0] a1; logic [1:0] z1; logic [63:0] d1;
    logic mr;
    logic r0; logic r1; logic wen; logic mis; logic [63:0] maddr;
  } vec_t;
  vec_t tbl[11];

  mem_wr_sched #(.DEPTH(4), .AW(64), .DW(64)) dut (
    .clk(clk), .rst(rst),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_addr(s0_addr), .s0_size(s0_size), .s0_data(s0_data),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_addr(s1_addr), .s1_size(s1_size), .s1_data(s1_data),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .q_empty(q_empty), .misalign(misalign), .misalign_addr(misalign_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [63:0] a, input logic [1:0] z, input logic [63:0] d);
    exp_t e;
    int unsigned n, o;
    e.addr = a; e.m = '0; e.d = '0;
    n = 32'd1 << z;
    o = 32'(a[2:0]);
    for (int unsigned b = 0; b < n; b++) begin
      e.m[o+b] = 1'b1;
      e.d[(o+b)*8 +: 8] = d[b*8 +: 8];
    end
    return e;
  endfunction

  function automatic logic aligned(input logic [63:0] a, input logic [1:0] z);
    return (a % (64'd1 << z)) == 64'd0;
  endfunction

  task automatic drive(input logic v0, input logic [63:0] a0, input logic [1:0] z0, input logic [63:0] d0,
                       input logic v1, input logic [63:0] a1, input logic [1:0] z1, input logic [63:0] d1,
                       input logic mr);
    s0_valid = v0; s0_addr = a0; s0_size = z0; s0_data = d0;
    s1_valid = v1; s1_addr = a1; s1_size = z1; s1_data = d1;
    mem_ready = mr;
  endtask

  task automatic idle(input logic mr);
    drive(0, 0, 0, 0, 0, 0, 0, 0, mr);
  endtask

  task automatic score();
    exp_t e;
    if (mem_wen && mem_ready) begin
      if (sb.size() == 0) begin
        compared++; mismatched++;
        $display("FAIL sb_unexpected_write: got addr %0h expected no write", mem_addr);
      end else begin
        e = sb.pop_front();
        chk("drain_addr", mem_addr, e.addr);
        chk("drain_wmask", 64'(mem_wmask), 64'(e.m));
        chk("drain_wdata", mem_wdata, e.d);
      end
    end
    if (s0_valid && s0_ready && aligned(s0_addr, s0_size)) sb.push_back(model(s0_addr, s0_size, s0_data));
    if (s1_valid && s1_ready && aligned(s1_addr, s1_size)) sb.push_back(model(s1_addr, s1_size, s1_data));
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b0; idle(0);
    @(negedge clk); rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; idle(0);
    tbl[0]  = '{1, 64'h100, 2'd3, 64'h1122334455667788, 1, 64'h206, 2'd1, 64'hBEEF, 1, 1, 0, 0, 0, 64'h0};
    tbl[1]  = '{1, 64'h108, 2'd3, 64'h99, 1, 64'h206, 2'd1, 64'hBEEF, 1, 0, 1, 1, 0, 64'h0};
    tbl[2]  = '{1, 64'h108, 2'd3, 64'h99, 1, 64'h20c, 2'd2, 64'hCAFEF00D, 1, 1, 0, 1, 0, 64'h0};
    tbl[3]  = '{1, 64'h110, 2'd0, 64'h5A, 1, 64'h20c, 2'd2, 64'hCAFEF00D, 1, 0, 1, 1, 0, 64'h0};
    tbl[4]  = '{0, 64'h0, 2'd0, 64'h0, 0, 64'h0, 2'd0, 64'h0, 1, 0, 0, 1, 0, 64'h0};
    tbl[5]  = '{0, 64'h0, 2'd0, 64'h0, 0, 64'h0, 2'd0, 64'h0, 1, 0, 0, 0, 0, 64'h0};
    tbl[6]  = '{0, 64'h0, 2'd0, 64'h0, 1, 64'h1002, 2'd2, 64'h12345678, 1, 0, 1, 0, 0, 64'h0};
    tbl[7]  = '{0, 64'h0, 2'd0, 64'h0, 1, 64'h1003, 2'd1, 64'h4321, 1, 0, 1, 0, 1, 64'h1002};
    tbl[8]  = '{1, 64'h5, 2'd3, 64'h77, 0, 64'h0, 2'd0, 64'h0, 1, 1, 0, 0, 1, 64'h1003};
    tbl[9]  = '{0, 64'h0, 2'd0, 64'h0, 0, 64'h0, 2'd0, 64'h0, 1, 0, 0, 0, 1, 64'h5};
    tbl[10] = '{0, 64'h0, 2'd0, 64'h0, 0, 64'h0, 2'd0, 64'h0, 1, 0, 0, 0, 0, 64'h0};

    do_reset();
    #2;
    chk("rst_mem_wen", 64'(mem_wen), 0);
    chk("rst_q_empty", 64'(q_empty), 1);
    chk("rst_misalign", 64'(misalign), 0);
    chk("rst_misalign_addr", misalign_addr, 0);
    chk("rst_mem_addr", mem_addr, 0);

    // Single byte store
    @(negedge clk); drive(1, 64'h80000003, 2'd0, 64'hAB, 0, 0, 0, 0, 0);
    #2; chk("single_s0_ready", 64'(s0_ready), 1); chk("single_wen_before", 64'(mem_wen), 0); score();
    @(negedge clk); idle(1);
    #2;
    chk("single_wen", 64'(mem_wen), 1);
    chk("single_addr", mem_addr, 64'h80000003);
    chk("single_wmask", 64'(mem_wmask), 64'h08);
    chk("single_wdata", mem_wdata, 64'h00000000AB000000);
    score();
    @(negedge clk); idle(1);
    #2; chk("single_q_empty", 64'(q_empty), 1); chk("single_wen_after", 64'(mem_wen), 0);

    // Vector table: contention and misaligned pulses, from a fresh round-robin state
    do_reset();
    for (int i = 0; i < 11; i++) begin
      if (i > 0) @(negedge clk);
      drive(tbl[i].v0, tbl[i].a0, tbl[i].z0, tbl[i].d0, tbl[i].v1, tbl[i].a1, tbl[i].z1, tbl[i].d1, tbl[i].mr);
      #2;
      chk($sformatf("row%0d_s0_ready", i), 64'(s0_ready), 64'(tbl[i].r0));
      chk($sformatf("row%0d_s1_ready", i), 64'(s1_ready), 64'(tbl[i].r1));
      chk($sformatf("row%0d_mem_wen", i), 64'(mem_wen), 64'(tbl[i].wen));
      chk($sformatf("row%0d_q_empty", i), 64'(q_empty), 64'(!tbl[i].wen));
      chk($sformatf("row%0d_misalign", i), 64'(misalign), 64'(tbl[i].mis));
      if (tbl[i].mis) chk($sformatf("row%0d_misalign_addr", i), misalign_addr, tbl[i].maddr);
      score();
    end

    // Full queue: fifth store blocked, including in the dequeue cycle
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); drive(1, 64'(8*i), 2'd3, 64'h1111 * 64'(i+1), 0, 0, 0, 0, 0);
      #2;
      chk($sformatf("full_s0_ready%0d", i), 64'(s0_ready), 64'(i < 4));
      score();
    end
    @(negedge clk); mem_ready = 1'b1;
    #2; chk("full_deq_cycle_ready", 64'(s0_ready), 0); chk("full_deq_cycle_wen", 64'(mem_wen), 1); score();
    @(negedge clk);
    #2; chk("full_after_deq_ready", 64'(s0_ready), 1); score();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); idle(1);
      #2;
      if (q_empty) break;
      score();
    end
    chk("full_drained", 64'(q_empty), 1);
    chk("full_sb_empty", 64'(sb.size()), 0);

    // Stall stability with one entry held
    @(negedge clk); drive(1, 64'h44, 2'd2, 64'hDEADBEEF, 0, 0, 0, 0, 0);
    #2; score();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); idle(0);
      #2;
      chk($sformatf("stall%0d_wen", i), 64'(mem_wen), 1);
      chk($sformatf("stall%0d_addr", i), mem_addr, 64'h44);
      chk($sformatf("stall%0d_wmask", i), 64'(mem_wmask), 64'hF0);
      chk($sformatf("stall%0d_wdata", i), mem_wdata, 64'hDEADBEEF00000000);
    end
    @(negedge clk); idle(1);
    #2; score();
    @(negedge clk); idle(0);
    #2; chk("stall_q_empty", 64'(q_empty), 1);

    // Reset mid-drain with the round-robin pointer left on s1
    @(negedge clk); drive(1, 64'h300, 2'd3, 64'h1, 0, 0, 0, 0, 0); #2; score();
    @(negedge clk); drive(0, 0, 0, 0, 1, 64'h308, 2'd3, 64'h2, 0); #2; score();
    @(negedge clk); drive(1, 64'h310, 2'd3, 64'h3, 0, 0, 0, 0, 0); #2; score();
    chk("pre_rst_count", 64'(sb.size()), 3);
    @(negedge clk); rst = 1'b0; idle(0);
    @(negedge clk); rst = 1'b1;
    sb.delete();
    drive(1, 64'h400, 2'd3, 64'hA, 1, 64'h500, 2'd3, 64'hB, 1);
    #2;
    chk("mid_rst_wen", 64'(mem_wen), 0);
    chk("mid_rst_q_empty", 64'(q_empty), 1);
    chk("mid_rst_addr", mem_addr, 0);
    chk("mid_rst_wmask", 64'(mem_wmask), 0);
    chk("mid_rst_wdata", mem_wdata, 0);
    chk("mid_rst_s0_ready", 64'(s0_ready), 1);
    chk("mid_rst_s1_ready", 64'(s1_ready), 0);
    score();
    @(negedge clk); idle(1);
    #2; chk("post_rst_wen", 64'(mem_wen), 1); score();
    @(negedge clk); idle(1);
    #2; chk("post_rst_empty", 64'(q_empty), 1);
    chk("final_sb_empty", 64'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
